// File: rtl/ad7606_pkg.sv
// -----------------------------------------------------------------------------
// ad7606_pkg
// Shared definitions for the AD7606 capture engine: frame sequencer state
// encoding, default AD7606 timing constants, OS/RANGE pin encodings and the
// frame period helper.
// -----------------------------------------------------------------------------
package ad7606_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IDLE = 3'd1,
        S_CONV = 3'd2,
        S_WBH  = 3'd3,
        S_WBL  = 3'd4,
        S_RDL  = 3'd5,
        S_RDH  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // Default AD7606 handshake timing, in system clock cycles.
    localparam int DEF_RESET_CYC        = 10;
    localparam int DEF_CONVST_LOW_CYC   = 5;
    localparam int DEF_RD_LOW_CYC       = 3;
    localparam int DEF_RD_HIGH_CYC      = 2;
    localparam int DEF_BUSY_TIMEOUT_CYC = 1000;

    // OS[2:0] encodings (oversampling ratio).
    localparam logic [2:0] OS_NONE = 3'b000;
    localparam logic [2:0] OS_X2   = 3'b001;
    localparam logic [2:0] OS_X4   = 3'b010;
    localparam logic [2:0] OS_X8   = 3'b011;
    localparam logic [2:0] OS_X16  = 3'b100;
    localparam logic [2:0] OS_X32  = 3'b101;
    localparam logic [2:0] OS_X64  = 3'b110;

    // RANGE pin encodings.
    localparam logic RANGE_5V  = 1'b0;
    localparam logic RANGE_10V = 1'b1;

    // Frame period in clock cycles from clock (MHz) and frame rate (kSPS).
    function automatic int period_cyc(input int clk_mhz, input int rate_ksps);
        return (clk_mhz * 1000) / rate_ksps;
    endfunction

endpackage

// File: rtl/ad7606_rate_gen.sv
// -----------------------------------------------------------------------------
// ad7606_rate_gen
// Free-running frame-rate counter 0..PERIOD_CYC-1. Runs only while enable is
// high and is held at zero otherwise, so a fresh enable always waits a full
// period before the first tick.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   enable in   count while high
//   tick   out  high while the count sits at PERIOD_CYC-1
// -----------------------------------------------------------------------------
module ad7606_rate_gen #(
    parameter int PERIOD_CYC = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(PERIOD_CYC - 1);

    logic [31:0] cnt_r;

    // Period counter, cleared whenever conversions are disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 32'd0;
        end else if (!enable) begin
            cnt_r <= 32'd0;
        end else if (cnt_r == LAST) begin
            cnt_r <= 32'd0;
        end else begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/ad7606_capture_v2.sv
// -----------------------------------------------------------------------------
// ad7606_capture_v2
// AD7606 parallel-bus capture engine. Paces conversions from an internal rate
// generator, runs the CONVST/BUSY/CS/RD handshake, reads NUM_CH words into a
// shadow buffer and publishes them atomically on ch_data_out.
// Optional feature macro: ADC_FRAME_CNT_EN (frame_cnt counts completed frames;
// when undefined frame_cnt is tied to zero).
// Ports:
//   sys_clk, rst_n          clock, synchronous active-low reset
//   adc_enable              run conversions while high
//   os_sel, range_sel       OS ratio / range requests, latched at frame start
//   err_clr                 clears sticky busy_timeout
//   adc_reset, adc_convst   AD7606 RESET / CONVST_A+B
//   adc_os, adc_range       AD7606 OS[2:0] / RANGE
//   adc_busy                AD7606 BUSY (asynchronous)
//   adc_cs_n, adc_rd_n      chip select / read strobe
//   adc_data                parallel data bus
//   ch_data_out             channel k in bits [16k+15:16k]
//   frame_valid, overrun    one-cycle pulses
//   busy_timeout            sticky BUSY timeout error
//   frame_cnt               completed frame counter
// -----------------------------------------------------------------------------
module ad7606_capture_v2 import ad7606_pkg::*; #(
    parameter int FPGA_CLOCK_FREQ   = 100,
    parameter int ADC_SAMPLING_RATE = 20,
    parameter int NUM_CH            = 8,
    parameter int RESET_CYC         = DEF_RESET_CYC,
    parameter int CONVST_LOW_CYC    = DEF_CONVST_LOW_CYC,
    parameter int RD_LOW_CYC        = DEF_RD_LOW_CYC,
    parameter int RD_HIGH_CYC       = DEF_RD_HIGH_CYC,
    parameter int BUSY_TIMEOUT_CYC  = DEF_BUSY_TIMEOUT_CYC
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  adc_enable,
    input  logic [2:0]            os_sel,
    input  logic                  range_sel,
    input  logic                  err_clr,
    output logic                  adc_reset,
    output logic                  adc_convst,
    output logic [2:0]            adc_os,
    output logic                  adc_range,
    input  logic                  adc_busy,
    output logic                  adc_cs_n,
    output logic                  adc_rd_n,
    input  logic [15:0]           adc_data,
    output logic [NUM_CH*16-1:0]  ch_data_out,
    output logic                  frame_valid,
    output logic                  busy_timeout,
    output logic                  overrun,
    output logic [31:0]           frame_cnt
);

    localparam int          PERIOD_CYC = period_cyc(FPGA_CLOCK_FREQ, ADC_SAMPLING_RATE);
    localparam logic [15:0] RST_LAST   = 16'(RESET_CYC - 1);
    localparam logic [15:0] CONV_LAST  = 16'(CONVST_LOW_CYC - 1);
    localparam logic [15:0] RDL_LAST   = 16'(RD_LOW_CYC - 1);
    localparam logic [15:0] RDH_LAST   = 16'(RD_HIGH_CYC - 1);
    localparam logic [31:0] TO_LAST    = 32'(BUSY_TIMEOUT_CYC - 1);
    localparam logic [2:0]  IDX_LAST   = 3'(NUM_CH - 1);

    state_t      state_r;
    logic [15:0] tmr_r;
    logic [31:0] to_cnt_r;
    logic [2:0]  idx_r;
    logic [15:0] shadow_r [NUM_CH];
    logic        busy_meta_r;
    logic        busy_s;
    logic        tick_s;

    ad7606_rate_gen #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_rate_gen (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .enable (adc_enable),
        .tick   (tick_s)
    );

    // Two-flop synchroniser for the asynchronous BUSY pin.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            busy_meta_r <= 1'b0;
            busy_s      <= 1'b0;
        end else begin
            busy_meta_r <= adc_busy;
            busy_s      <= busy_meta_r;
        end
    end

    // Frame sequencer: handshake, timeout recovery and all registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_r      <= S_RST;
            tmr_r        <= 16'd0;
            to_cnt_r     <= 32'd0;
            idx_r        <= 3'd0;
            adc_reset    <= 1'b1;
            adc_convst   <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            adc_os       <= OS_NONE;
            adc_range    <= RANGE_5V;
            ch_data_out  <= {(NUM_CH*16){1'b0}};
            frame_valid  <= 1'b0;
            busy_timeout <= 1'b0;
            overrun      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_r[k] <= 16'h0000;
            end
        end else begin
            frame_valid <= 1'b0;
            // A tick is only consumed in S_IDLE; anywhere else it is dropped.
            overrun     <= tick_s && (state_r != S_IDLE);
            // A timeout raised below in the same cycle overrides this clear.
            if (err_clr) begin
                busy_timeout <= 1'b0;
            end else begin
                busy_timeout <= busy_timeout;
            end

            case (state_r)
                S_RST: begin
                    if (tmr_r == RST_LAST) begin
                        adc_reset <= 1'b0;
                        tmr_r     <= 16'd0;
                        state_r   <= S_IDLE;
                    end else begin
                        tmr_r <= tmr_r + 16'd1;
                    end
                end
                S_IDLE: begin
                    if (tick_s) begin
                        adc_os     <= os_sel;
                        adc_range  <= range_sel;
                        adc_convst <= 1'b0;
                        tmr_r      <= 16'd0;
                        state_r    <= S_CONV;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CONV: begin
                    if (tmr_r == CONV_LAST) begin
                        adc_convst <= 1'b1;
                        to_cnt_r   <= 32'd0;
                        state_r    <= S_WBH;
                    end else begin
                        tmr_r <= tmr_r + 16'd1;
                    end
                end
                // One timeout counter spans both BUSY wait states.
                S_WBH: begin
                    if (to_cnt_r == TO_LAST) begin
                        busy_timeout <= 1'b1;
                        adc_reset    <= 1'b1;
                        tmr_r        <= 16'd0;
                        state_r      <= S_RST;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                        if (busy_s) begin
                            state_r <= S_WBL;
                        end else begin
                            state_r <= S_WBH;
                        end
                    end
                end
                S_WBL: begin
                    if (to_cnt_r == TO_LAST) begin
                        busy_timeout <= 1'b1;
                        adc_reset    <= 1'b1;
                        tmr_r        <= 16'd0;
                        state_r      <= S_RST;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                        if (!busy_s) begin
                            adc_cs_n <= 1'b0;
                            adc_rd_n <= 1'b0;
                            idx_r    <= 3'd0;
                            tmr_r    <= 16'd0;
                            state_r  <= S_RDL;
                        end else begin
                            state_r <= S_WBL;
                        end
                    end
                end
                S_RDL: begin
                    if (tmr_r == RDL_LAST) begin
                        shadow_r[idx_r] <= adc_data;
                        adc_rd_n        <= 1'b1;
                        tmr_r           <= 16'd0;
                        state_r         <= S_RDH;
                    end else begin
                        tmr_r <= tmr_r + 16'd1;
                    end
                end
                S_RDH: begin
                    if (tmr_r == RDH_LAST) begin
                        tmr_r <= 16'd0;
                        if (idx_r == IDX_LAST) begin
                            state_r <= S_DONE;
                        end else begin
                            idx_r    <= idx_r + 3'd1;
                            adc_rd_n <= 1'b0;
                            state_r  <= S_RDL;
                        end
                    end else begin
                        tmr_r <= tmr_r + 16'd1;
                    end
                end
                S_DONE: begin
                    adc_cs_n <= 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        ch_data_out[16*k +: 16] <= shadow_r[k];
                    end
                    frame_valid <= 1'b1;
                    state_r     <= S_IDLE;
                end
                default: begin
                    adc_reset  <= 1'b1;
                    adc_convst <= 1'b1;
                    adc_cs_n   <= 1'b1;
                    adc_rd_n   <= 1'b1;
                    tmr_r      <= 16'd0;
                    state_r    <= S_RST;
                end
            endcase
        end
    end

`ifdef ADC_FRAME_CNT_EN
    logic [31:0] frame_cnt_r;

    // Completed-frame counter, stepping with frame_valid and wrapping at 2^32.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            frame_cnt_r <= 32'd0;
        end else if (state_r == S_DONE) begin
            frame_cnt_r <= frame_cnt_r + 32'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 32'd0;
`endif

endmodule
